// File: rtl/rotator_arbiter.sv
// Round-robin front end for one shared right-rotator: picks a requester, drives the rotator,
// and returns results in acceptance order through a credit-protected 2-entry buffer.
// Optional burst locking is compiled in with ROTATOR_ARB_LOCK_EN (adds the req_lock port).
module rotator_arbiter #(
   parameter int NUM_REQ            = 4,
   parameter int DATAWIDTH          = 32,
   parameter int SHIFTBITS_PER_STEP = 1,
   parameter int ROT_LATENCY        = 1,
   localparam int ROTW = $clog2(DATAWIDTH / SHIFTBITS_PER_STEP),
   localparam int IDW  = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATAWIDTH-1:0] req_data,
   input  logic [NUM_REQ*ROTW-1:0]   req_rot,
`ifdef ROTATOR_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        req_lock,
`endif
   output logic [DATAWIDTH-1:0]      rot_data_in,
   output logic [ROTW-1:0]           rot_rotation_right,
   input  logic [DATAWIDTH-1:0]      rot_data_out,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATAWIDTH-1:0]      out_data,
   output logic [IDW-1:0]            out_id
);

   logic [IDW-1:0]       ptr;
   logic [IDW-1:0]       ptr_next;
   logic [IDW-1:0]       winner;
   logic [IDW-1:0]       hi_idx;
   logic [IDW-1:0]       lo_idx;
   logic                 hi_any;
   logic                 lo_any;
   logic                 any_valid;
   logic                 has_credit;
   logic                 issue;
   logic                 accept;
   logic                 lock_sel;
   logic                 pop;
   logic                 push;
   logic [DATAWIDTH-1:0] push_data;
   logic [IDW-1:0]       push_id;
   logic                 inflight_q;
   logic [1:0]           occ;
   logic [2:0]           load;
   logic [2:0]           limit;
   logic [DATAWIDTH-1:0] head_data;
   logic [DATAWIDTH-1:0] tail_data;
   logic [IDW-1:0]       head_id;
   logic [IDW-1:0]       tail_id;

   // Lowest valid index at/after the pointer wins; otherwise wrap to the lowest valid index.
   always_comb begin
      hi_any = 1'b0;
      lo_any = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_any = 1'b1;
            lo_idx = IDW'(i);
            if (IDW'(i) >= ptr) begin
               hi_any = 1'b1;
               hi_idx = IDW'(i);
            end
         end
      end
      any_valid = lo_any;
      winner    = hi_any ? hi_idx : lo_idx;
   end

   assign pop        = out_valid & out_ready;
   assign load       = {1'b0, occ} + {2'b00, inflight_q};
   assign limit      = 3'd2 + {2'b00, pop};
   assign has_credit = load < limit;
   assign issue      = any_valid & has_credit & ~reset;

   always_comb begin
      req_ready          = '0;
      rot_data_in        = '0;
      rot_rotation_right = '0;
      lock_sel           = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (issue && (winner == IDW'(i))) begin
            req_ready[i]       = 1'b1;
            rot_data_in        = req_data[i*DATAWIDTH +: DATAWIDTH];
            rot_rotation_right = req_rot[i*ROTW +: ROTW];
`ifdef ROTATOR_ARB_LOCK_EN
            lock_sel           = req_lock[i];
`endif
         end
      end
   end

   assign accept = |(req_valid & req_ready);

   // A locked winner keeps the pointer on itself; it loses priority once it drops valid.
   always_comb begin
      ptr_next = ptr;
      if (accept) begin
         if (lock_sel)
            ptr_next = winner;
         else if (winner == IDW'(NUM_REQ - 1))
            ptr_next = '0;
         else
            ptr_next = winner + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else
         ptr <= ptr_next;
   end

   assign push_data = rot_data_out;

   if (ROT_LATENCY == 0) begin : g_lat0
      assign inflight_q = 1'b0;
      assign push       = accept;
      assign push_id    = winner;
   end else begin : g_lat1
      logic [IDW-1:0] inflight_id;
      always_ff @(posedge clk) begin
         if (reset) begin
            inflight_q  <= 1'b0;
            inflight_id <= '0;
         end else begin
            inflight_q  <= accept;
            inflight_id <= winner;
         end
      end
      assign push    = inflight_q;
      assign push_id = inflight_id;
   end

   // Two-slot buffer, head slot drives the output directly.
   always_ff @(posedge clk) begin
      if (reset) begin
         occ       <= 2'd0;
         head_data <= '0;
         head_id   <= '0;
         tail_data <= '0;
         tail_id   <= '0;
      end else begin
         case (occ)
            2'd0: begin
               if (push) begin
                  head_data <= push_data;
                  head_id   <= push_id;
                  occ       <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  head_data <= push_data;
                  head_id   <= push_id;
               end else if (push) begin
                  tail_data <= push_data;
                  tail_id   <= push_id;
                  occ       <= 2'd2;
               end else if (pop) begin
                  occ <= 2'd0;
               end
            end
            default: begin
               if (pop) begin
                  head_data <= tail_data;
                  head_id   <= tail_id;
                  if (push) begin
                     tail_data <= push_data;
                     tail_id   <= push_id;
                  end else begin
                     occ <= 2'd1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && (occ == 2'd2) && !pop)
         assert (!push);
   end

   assign out_valid = (occ != 2'd0);
   assign out_data  = head_data;
   assign out_id    = head_id;

endmodule

// File: doc/rotator_arbiter.md
Name: rotator_arbiter

Overview:
- Shares one barrelShifterRight instance between NUM_REQ requesters.
- Arbitrates round-robin, drives the rotator's dataIn/rotationRight, tracks results in flight through the rotator's optional output register, and returns each result with its requester id on a valid/ready output stream.
- Credit-controlled 2-entry result buffer; sustains 1 rotation/cycle when the consumer is always ready.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATAWIDTH, 32, data width; equals rotator INPUTWIDTH = OUTPUTWIDTH.
- SHIFTBITS_PER_STEP, 1, rotation granularity in bits; DATAWIDTH/SHIFTBITS_PER_STEP must be a power of two.
- ROT_LATENCY, 1, rotator latency in cycles: 0 or 1. Must match the rotator's OUTPUT_REGISTER setting.
- Derived ROTW = $clog2(DATAWIDTH/SHIFTBITS_PER_STEP).
- Derived IDW = max(1, $clog2(NUM_REQ)).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_data  in  NUM_REQ*DATAWIDTH  flattened request data; requester i occupies [i*DATAWIDTH +: DATAWIDTH].
- req_rot  in  NUM_REQ*ROTW  flattened right-rotation amounts, in steps.
- rot_data_in  out  DATAWIDTH  to rotator dataIn.
- rot_rotation_right  out  ROTW  to rotator rotationRight.
- rot_data_out  in  DATAWIDTH  from rotator dataOut.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accept.
- out_data  out  DATAWIDTH  rotated result.
- out_id  out  IDW  index of the originating requester.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_id=0, req_ready=0, RR pointer=0, buffer empty, in-flight clear. Reset mid-operation discards all buffered and in-flight results; no output appears for them.
- Credit: credit = 2 - occupancy - inflight + (out_valid & out_ready). A pop in the same cycle frees its slot.
- Issue: allowed when credit>0 and any req_valid is high.
  - Winner = first valid index at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[winner]=1; req_ready may depend combinationally on req_valid.
  - Accept when req_valid[i] & req_ready[i]. On accept, pointer <= winner+1, wrapping to 0 after NUM_REQ-1. With no accept, the pointer holds.
- Rotator drive: rot_data_in/rot_rotation_right = winner's req_data/req_rot in the accept cycle; otherwise 0.
- Latency: accept in cycle T gives out_valid in cycle T+1+ROT_LATENCY, assuming the buffer ahead of it is drained.
  - ROT_LATENCY=1: one-bit in-flight register plus id register; the result is captured from rot_data_out the cycle after accept.
- Buffer: 2-entry FIFO of {data,id}, head on out_data/out_id.
  - Push and pop in the same cycle is legal at any occupancy.
  - A push when full cannot occur (credit guarantees it); verification asserts this.
- Ordering: results leave in acceptance order.
- out_valid held with out_data/out_id stable until out_ready.
- Rotation value 0: data passes unchanged. Max value (2^ROTW-1): rotate right by (2^ROTW-1)*SHIFTBITS_PER_STEP bits.
- Simultaneous requests: exactly one grant per cycle; the others wait. Starvation-free; worst-case wait is NUM_REQ-1 grants.

Optional Feature:
- Macro: ROTATOR_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock (NUM_REQ).
  - If the accepted requester has req_lock[i]=1, the pointer is set to i instead of i+1, so i keeps priority next cycle (burst).
  - The lock releases on the first accept with req_lock[i]=0, or the first cycle with req_valid[i]=0.
- Undefined: port absent; pure round-robin.

Test Plan:
- Single request: req 2 valid, data 0x0000_00F1, rot 4, ROT_LATENCY=1, out_ready=1 -> accept cycle T; out_valid at T+2, out_data 0x1000_000F, out_id 2.
- All 4 valid continuously, out_ready=1, pointer 0 -> grants 0,1,2,3,0,...; one result/cycle; ids in the same order.
- out_ready=0 for 10 cycles with all valid -> exactly 2 accepts, then req_ready all 0. Raise out_ready -> both results drain in order, then throughput returns to 1/cycle.
- ROT_LATENCY=0, rot 0 and rot 31 on 0x8000_0001 -> out_data 0x8000_0001 and 0x0000_0003 (rotate right 31 bits); out_valid at T+1.
- reset asserted for 1 cycle with 2 buffered + 1 in flight -> next cycle out_valid=0, pointer 0; no stale result ever appears.
- ROTATOR_ARB_LOCK_EN: req 1 valid with lock for 3 accepts while req 0 and req 3 are also valid -> grants 1,1,1, then 3 after lock drops.
